// File: rtl/accumulator_sequencer_pkg.sv
// Shared opcode and state definitions for the accumulator control sequencer.
package accumulator_sequencer_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_NOP   = 3'b000;
    localparam logic [OP_W-1:0] OP_RESET = 3'b001;
    localparam logic [OP_W-1:0] OP_SHR   = 3'b010;
    localparam logic [OP_W-1:0] OP_ADD   = 3'b011;
    localparam logic [OP_W-1:0] OP_INC   = 3'b100;
    localparam logic [OP_W-1:0] OP_SWAP  = 3'b101;
    localparam logic [OP_W-1:0] OP_CMPL  = 3'b110;
    localparam logic [OP_W-1:0] OP_MUL   = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_EXEC    = 3'd1,
        S_MULT    = 3'd2,
        S_MULT_LD = 3'd3,
        S_DONE    = 3'd4
    } state_t;

endpackage

// File: rtl/mult_wait_counter.sv
// Down-counter timing the fixed multiply wait; loaded on MUL accept, never wraps.
module mult_wait_counter #(
    parameter int MULT_CYCLES = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic dec,
    output logic zero
);

    localparam int CW = $clog2(MULT_CYCLES + 1);
    localparam logic [CW-1:0] LOAD_VAL = CW'(MULT_CYCLES - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= LOAD_VAL;
        end else if (dec && (count != '0)) begin
            count <= count - CW'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/accumulator_sequencer.sv
// Sequences one-hot accumulator controls from a start/opcode pair; outputs are
// decoded from registered state only, so start/opcode never reach an output directly.
module accumulator_sequencer
    import accumulator_sequencer_pkg::*;
#(
    parameter int MULT_CYCLES = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [OP_W-1:0] opcode,
    output logic            Reset_AC,
    output logic            ShiftRight_AC,
    output logic            Add_Input_AC,
    output logic            Increment_AC,
    output logic            Swaprightleft_AC,
    output logic            Complement_AC,
    output logic            Multiply_AC,
    output logic            alu_on_bus,
    output logic            ld_AC,
    output logic            busy,
    output logic            done
);

    state_t          state;
    state_t          state_nxt;
    logic [OP_W-1:0] op_q;
    logic            accept;
    logic            cnt_load;
    logic            cnt_zero;

    assign accept   = (state == S_IDLE) && start;
    assign cnt_load = accept && (opcode == OP_MUL);

    mult_wait_counter #(
        .MULT_CYCLES(MULT_CYCLES)
    ) u_wait (
        .clk   (clk),
        .reset (reset),
        .load  (cnt_load),
        .dec   (state == S_MULT),
        .zero  (cnt_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            op_q  <= OP_NOP;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q <= opcode;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start) state_nxt = (opcode == OP_MUL) ? S_MULT : S_EXEC;
            S_EXEC:    state_nxt = S_DONE;
            S_MULT:    if (cnt_zero) state_nxt = S_MULT_LD;
            S_MULT_LD: state_nxt = S_DONE;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        Reset_AC         = 1'b0;
        ShiftRight_AC    = 1'b0;
        Add_Input_AC     = 1'b0;
        Increment_AC     = 1'b0;
        Swaprightleft_AC = 1'b0;
        Complement_AC    = 1'b0;
        Multiply_AC      = 1'b0;
        alu_on_bus       = 1'b0;
        ld_AC            = 1'b0;
        busy             = (state != S_IDLE);
        done             = (state == S_DONE);
        case (state)
            S_EXEC: begin
                // NOP leaves the bus and load idle; every other EXEC opcode loads the ALU result.
                alu_on_bus = (op_q != OP_NOP);
                ld_AC      = (op_q != OP_NOP);
                case (op_q)
                    OP_RESET: Reset_AC         = 1'b1;
                    OP_SHR:   ShiftRight_AC    = 1'b1;
                    OP_ADD:   Add_Input_AC     = 1'b1;
                    OP_INC:   Increment_AC     = 1'b1;
                    OP_SWAP:  Swaprightleft_AC = 1'b1;
                    OP_CMPL:  Complement_AC    = 1'b1;
                    default: begin
                        alu_on_bus = 1'b0;
                        ld_AC      = 1'b0;
                    end
                endcase
            end
            S_MULT:    Multiply_AC = 1'b1;
            S_MULT_LD: begin
                Multiply_AC = 1'b1;
                ld_AC       = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_accumulator_sequencer.sv
// Bench for accumulator_sequencer: timeline model of expected output vectors plus directed literal checks.
module tb_accumulator_sequencer;

    localparam int MC = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [2:0] opcode;
    logic Reset_AC, ShiftRight_AC, Add_Input_AC, Increment_AC;
    logic Swaprightleft_AC, Complement_AC, Multiply_AC;
    logic alu_on_bus, ld_AC, busy, done;

    always #5 clk = ~clk;

    accumulator_sequencer #(.MULT_CYCLES(MC)) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .opcode           (opcode),
        .Reset_AC         (Reset_AC),
        .ShiftRight_AC    (ShiftRight_AC),
        .Add_Input_AC     (Add_Input_AC),
        .Increment_AC     (Increment_AC),
        .Swaprightleft_AC (Swaprightleft_AC),
        .Complement_AC    (Complement_AC),
        .Multiply_AC      (Multiply_AC),
        .alu_on_bus       (alu_on_bus),
        .ld_AC            (ld_AC),
        .busy             (busy),
        .done             (done)
    );

    // {Reset,Shr,Add,Inc,Swap,Cmpl,Mul, alu_on_bus, ld_AC, busy, done}
    logic [10:0] act;
    assign act = {Reset_AC, ShiftRight_AC, Add_Input_AC, Increment_AC, Swaprightleft_AC,
                  Complement_AC, Multiply_AC, alu_on_bus, ld_AC, busy, done};

    int checks = 0;
    int errors = 0;
    int n_mul, n_ld, n_alu, n_done, n_rst_ac, n_inc, n_busy;

    // Per-cycle expected output vectors, front entry = what the DUT shows this cycle.
    logic [10:0] exp_q[$];

    function automatic void push_op(input logic [2:0] op);
        logic [10:0] v;
        if (op == 3'd7) begin
            for (int i = 0; i < MC; i++) exp_q.push_back(11'b0000001_0010);
            exp_q.push_back(11'b0000001_0110);
        end else if (op == 3'd0) begin
            exp_q.push_back(11'b0000000_0010);
        end else begin
            v = 11'b0000000_1110;
            v[11 - int'(op)] = 1'b1;
            exp_q.push_back(v);
        end
        exp_q.push_back(11'b0000000_0011);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_q.delete();
        end else if (exp_q.size() == 0) begin
            if (start) push_op(opcode);
        end else begin
            void'(exp_q.pop_front());
        end
    end

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d at %0t", name, got, want, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [10:0] e;
        e = (exp_q.size() != 0) ? exp_q[0] : 11'b0;
        if (reset) e = 11'b0;
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL model_cmp got %b want %b at %0t", act, e, $time);
        end
        checks++;
        if (($countones(act[10:4]) > 1) || (alu_on_bus && Multiply_AC)) begin
            errors++;
            $display("FAIL invariant got %b at %0t", act, $time);
        end
        if (!reset) begin
            n_mul    += int'(Multiply_AC);
            n_ld     += int'(ld_AC);
            n_alu    += int'(alu_on_bus);
            n_done   += int'(done);
            n_rst_ac += int'(Reset_AC);
            n_inc    += int'(Increment_AC);
            n_busy   += int'(busy);
        end
    end

    task automatic clr_tally();
        n_mul = 0; n_ld = 0; n_alu = 0; n_done = 0; n_rst_ac = 0; n_inc = 0; n_busy = 0;
    endtask

    // Returns just after the accepting edge N.
    task automatic issue(input logic [2:0] op);
        @(posedge clk);
        #1 start = 1'b1;
        opcode = op;
        @(posedge clk);
        #1 start = 1'b0;
        opcode = 3'($urandom_range(0, 7));
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (!done && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("wait_done", int'(done), 1);
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        opcode = 3'd0;
        clr_tally();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        clr_tally();
        repeat (10) @(negedge clk);
        check("idle_busy_cycles", n_busy, 0);
        check("idle_done_cycles", n_done, 0);
        check("idle_outputs", int'(act), 0);

        issue(3'd3);
        @(negedge clk);
        check("add_ctrl", int'({Add_Input_AC, alu_on_bus, ld_AC, done}), 4'b1110);
        @(negedge clk);
        check("add_done", int'({Add_Input_AC, alu_on_bus, ld_AC, done}), 4'b0001);
        @(negedge clk);
        check("add_idle", int'(busy), 0);

        clr_tally();
        issue(3'd7);
        repeat (14) @(negedge clk);
        check("mul_cycles", n_mul, MC + 1);
        check("mul_ld", n_ld, 1);
        check("mul_alu", n_alu, 0);
        check("mul_done", n_done, 1);

        clr_tally();
        issue(3'd7);
        repeat (2) @(posedge clk);
        #1 start = 1'b1;
        opcode = 3'd1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (14) @(negedge clk);
        check("ignored_reset_ac", n_rst_ac, 0);
        check("ignored_done", n_done, 1);

        clr_tally();
        issue(3'd7);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("rst_mid_outputs", int'(act), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (12) @(negedge clk);
        check("rst_mid_ld", n_ld, 0);
        check("rst_mid_done", n_done, 0);
        check("rst_mid_busy", int'(busy), 0);
        clr_tally();
        issue(3'd4);
        wait_done();
        @(negedge clk);
        check("inc_after_rst", n_inc, 1);
        check("inc_done", n_done, 1);

        for (int op = 0; op < 8; op++) begin
            issue(3'(op));
            wait_done();
        end
        repeat (3) @(negedge clk);

        clr_tally();
        issue(3'd0);
        wait_done();
        @(negedge clk);
        check("nop_ld", n_ld, 0);
        check("nop_alu", n_alu, 0);
        check("nop_done", n_done, 1);

        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1 start = 1'($urandom_range(0, 1));
            opcode = 3'($urandom_range(0, 7));
        end
        #1 start = 1'b0;
        repeat (20) @(negedge clk);
        check("drain_busy", int'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
